// File: rtl/dmem_pkg.sv
// Shared encodings and defaults for the MEM-stage data memory responder.
package dmem_pkg;

    localparam int DEPTH_WORDS_DEF = 256;
    localparam int LATENCY_DEF     = 2;

    localparam logic [1:0] OP_NONE  = 2'b00;
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    // Only load and store start an operation; 2'b11 behaves like none.
    function automatic logic is_mem_op(input logic [1:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, combinational read, contents never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    // Write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data memory responder: accepts one load/store in IDLE, acks after LATENCY cycles.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter int LATENCY     = LATENCY_DEF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic [1:0]  Mem_i,
    input  logic [31:0] Memaddr_i,
    input  logic [31:0] Memdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam int              AW         = $clog2(DEPTH_WORDS);
    localparam int              CW         = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [32:0]     ADDR_LIMIT = 33'(DEPTH_WORDS) << 2;
    localparam logic [CW-1:0]   CNT_LOAD   = CW'(LATENCY - 1);
    localparam logic [CW-1:0]   CNT_ONE    = CW'(1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_rdata;
    logic          r_ack;
    logic          r_err;
    logic          r_err_pend;

    logic          w_accept;
    logic          w_err;
    logic          w_we;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rd;

    // Reset blocks acceptance so nothing is written while rst_i is high.
    assign w_accept = (r_state == ST_IDLE) && req_i && is_mem_op(Mem_i) && !rst_i;
    assign w_err    = (Memaddr_i[1:0] != 2'b00) || ({1'b0, Memaddr_i} >= ADDR_LIMIT);
    assign w_idx    = Memaddr_i[AW+1:2];
    assign w_we     = w_accept && (Mem_i == OP_STORE) && !w_err;
    assign stall_o  = w_accept || (r_state == ST_BUSY);

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .i_clk   (clk_i),
        .i_we    (w_we),
        .i_addr  (w_idx),
        .i_wdata (Memdata_i),
        .o_rdata (w_rd)
    );

    // Control FSM with latency counter; err is held pending until the ack cycle
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_rdata    <= 32'h0000_0000;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_err_pend <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_err_pend <= w_err;
                        if (w_err) begin
                            r_rdata <= 32'h0000_0000;
                        end else if (Mem_i == OP_LOAD) begin
                            r_rdata <= w_rd;
                        end
                        if (LATENCY == 1) begin
                            r_state <= ST_RESP;
                            r_ack   <= 1'b1;
                            r_err   <= w_err;
                        end else begin
                            r_state <= ST_BUSY;
                            r_cnt   <= CNT_LOAD;
                        end
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == CNT_ONE) begin
                        r_state <= ST_RESP;
                        r_cnt   <= '0;
                        r_ack   <= 1'b1;
                        r_err   <= r_err_pend;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign rdata_o = r_rdata;
    assign ack_o   = r_ack;
    assign err_o   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized bench for dmem_responder: LATENCY=2 and LATENCY=1 instances against a word-level model.
module tb_dmem_responder;
    import dmem_pkg::*;

    localparam int DEPTH = 256;
    localparam int LAT0  = 2;
    localparam int LAT1  = 1;

    logic             clk = 1'b0;
    logic [1:0]       rst_s;
    logic [1:0]       req_s;
    logic [1:0][1:0]  mem_s;
    logic [1:0][31:0] addr_s;
    logic [1:0][31:0] wdata_s;
    logic [1:0][31:0] rdata_s;
    logic [1:0]       ack_s;
    logic [1:0]       err_s;
    logic [1:0]       stall_s;

    logic [31:0] m_mem [2][DEPTH];
    bit          m_vld [2][DEPTH];
    logic [31:0] m_rdata [2];
    bit          m_rd_known [2];
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT0)) u_dut0 (
        .clk_i(clk), .rst_i(rst_s[0]), .req_i(req_s[0]), .Mem_i(mem_s[0]),
        .Memaddr_i(addr_s[0]), .Memdata_i(wdata_s[0]), .rdata_o(rdata_s[0]),
        .ack_o(ack_s[0]), .err_o(err_s[0]), .stall_o(stall_s[0])
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(LAT1)) u_dut1 (
        .clk_i(clk), .rst_i(rst_s[1]), .req_i(req_s[1]), .Mem_i(mem_s[1]),
        .Memaddr_i(addr_s[1]), .Memdata_i(wdata_s[1]), .rdata_o(rdata_s[1]),
        .ack_o(ack_s[1]), .err_o(err_s[1]), .stall_o(stall_s[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic neutral(input int d);
        req_s[d]   = 1'b0;
        mem_s[d]   = OP_NONE;
        addr_s[d]  = 32'h0000_0000;
        wdata_s[d] = 32'h0000_0000;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
        if (r == 1) return $urandom | 32'h0000_0400;
        return 32'($urandom_range(0, 15) * 4);
    endfunction

    // One operation on instance d; checks stall, ack timing, err and rdata cycle by cycle.
    task automatic do_op(input int d, input logic [1:0] op, input logic [31:0] a, input logic [31:0] wd);
        int lat_d;
        bit e;
        int w;
        lat_d = (d == 0) ? LAT0 : LAT1;
        e = (a % 4 != 0) || (a >= 32'(DEPTH * 4));
        w = int'(a / 4);
        req_s[d] = 1'b1; mem_s[d] = op; addr_s[d] = a; wdata_s[d] = wd;
        #1;
        chk("stall_accept", 32'(stall_s[d]), 32'd1);
        if (e) begin
            m_rdata[d] = 32'h0000_0000;
            m_rd_known[d] = 1'b1;
        end else if (op == OP_STORE) begin
            m_mem[d][w] = wd;
            m_vld[d][w] = 1'b1;
        end else begin
            m_rdata[d] = m_mem[d][w];
            m_rd_known[d] = m_vld[d][w];
        end
        for (int k = 1; k <= lat_d; k++) begin
            step();
            chk("ack", 32'(ack_s[d]), 32'(k == lat_d));
            chk("err", 32'(err_s[d]), 32'((k == lat_d) && e));
            if (k == lat_d && m_rd_known[d]) chk("rdata", rdata_s[d], m_rdata[d]);
            req_s[d] = 1'($urandom); mem_s[d] = 2'($urandom);
            addr_s[d] = $urandom; wdata_s[d] = $urandom;
            #1;
            chk("stall_busy", 32'(stall_s[d]), 32'(k < lat_d));
        end
        step();
        chk("ack_after", 32'(ack_s[d]), 32'd0);
        chk("err_after", 32'(err_s[d]), 32'd0);
        neutral(d);
    endtask

    // Non-accepting IDLE cycles: req low or op none/reserved must never stall.
    task automatic idle(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            req_s[d] = 1'($urandom);
            mem_s[d] = req_s[d] ? (($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11) : 2'($urandom);
            addr_s[d] = $urandom; wdata_s[d] = $urandom;
            #1;
            chk("stall_idle", 32'(stall_s[d]), 32'd0);
            step();
            chk("ack_idle", 32'(ack_s[d]), 32'd0);
            chk("err_idle", 32'(err_s[d]), 32'd0);
        end
        neutral(d);
    endtask

    initial begin
        logic [1:0] op;
        rst_s = 2'b11;
        neutral(0);
        neutral(1);
        for (int d = 0; d < 2; d++) begin
            m_rdata[d] = 32'h0000_0000;
            m_rd_known[d] = 1'b1;
            for (int w = 0; w < DEPTH; w++) m_vld[d][w] = 1'b0;
        end
        step(); step(); step();
        for (int d = 0; d < 2; d++) begin
            chk("rst_rdata", rdata_s[d], 32'h0000_0000);
            chk("rst_ack", 32'(ack_s[d]), 32'd0);
            chk("rst_err", 32'(err_s[d]), 32'd0);
        end
        rst_s = 2'b00;
        step();
        chk("stall_after_rst0", 32'(stall_s[0]), 32'd0);
        chk("stall_after_rst1", 32'(stall_s[1]), 32'd0);

        do_op(0, OP_STORE, 32'h0000_0000, 32'h1122_3344);
        do_op(0, OP_STORE, 32'h0000_0010, 32'hDEAD_BEEF);
        do_op(0, OP_LOAD,  32'h0000_0010, $urandom);
        do_op(0, OP_LOAD,  32'h0000_0013, $urandom);
        do_op(0, OP_LOAD,  32'h0000_0010, $urandom);
        do_op(0, OP_STORE, 32'h0000_0400, 32'hBAD0_BAD0);
        do_op(0, OP_LOAD,  32'h0000_0000, $urandom);
        do_op(0, OP_STORE, 32'h0000_03FC, 32'hCAFE_F00D);
        do_op(0, OP_LOAD,  32'h0000_03FC, $urandom);
        do_op(0, OP_STORE, 32'h0000_0004, 32'h5555_AAAA);
        idle(0, 4);

        // Reset during BUSY of a store: no ack, but the write stays.
        req_s[0] = 1'b1; mem_s[0] = OP_STORE; addr_s[0] = 32'h0000_0020; wdata_s[0] = 32'hA5A5_0020;
        #1;
        chk("stall_rst_accept", 32'(stall_s[0]), 32'd1);
        m_mem[0][8] = 32'hA5A5_0020;
        m_vld[0][8] = 1'b1;
        step();
        neutral(0);
        rst_s[0] = 1'b1;
        step();
        chk("midrst_ack", 32'(ack_s[0]), 32'd0);
        chk("midrst_err", 32'(err_s[0]), 32'd0);
        chk("midrst_rdata", rdata_s[0], 32'h0000_0000);
        chk("midrst_stall", 32'(stall_s[0]), 32'd0);
        m_rdata[0] = 32'h0000_0000;
        rst_s[0] = 1'b0;
        step();
        chk("midrst_ack2", 32'(ack_s[0]), 32'd0);
        chk("midrst_stall2", 32'(stall_s[0]), 32'd0);
        do_op(0, OP_LOAD, 32'h0000_0020, $urandom);

        for (int w = 0; w < 16; w++) begin
            do_op(0, OP_STORE, 32'(w * 4), $urandom);
            do_op(1, OP_STORE, 32'(w * 4), $urandom);
        end

        idle(1, 6);
        for (int i = 0; i < 40; i++) begin
            op = (i % 2 == 0) ? OP_LOAD : OP_STORE;
            do_op(1, op, rand_addr(), $urandom);
        end
        idle(1, 4);

        for (int i = 0; i < 60; i++) begin
            op = ($urandom_range(0, 1) == 0) ? OP_LOAD : OP_STORE;
            do_op(0, op, rand_addr(), $urandom);
            if ($urandom_range(0, 3) == 0) idle(0, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 256, number of 32-bit words held; SHALL be a power of two.
REQ-002 Parameter LATENCY, default 2, cycles from request acceptance to ack_o; SHALL be >= 1.
REQ-003 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst_i  input  1  reset; SHALL be synchronous and active-high.
REQ-005 req_i  input  1  MEM-stage request valid.
REQ-006 Mem_i  input  2  operation: 2'b00 none, 2'b01 load, 2'b10 store, 2'b11 reserved (treated as none).
REQ-007 Memaddr_i  input  32  byte address from EX/MEM.
REQ-008 Memdata_i  input  32  store data.
REQ-009 rdata_o  output  32  load data, valid in the ack_o cycle.
REQ-010 ack_o  output  1  one-cycle completion pulse.
REQ-011 err_o  output  1  error flag, valid in the ack_o cycle.
REQ-012 stall_o  output  1  freeze request to the pipeline.

Function
REQ-013 The FSM SHALL have three states: IDLE, BUSY, RESP.
REQ-014 A request SHALL be accepted only in IDLE, when req_i=1 and Mem_i is 01 or 10; every other input combination in IDLE SHALL be ignored.
REQ-015 On acceptance: go to RESP if LATENCY=1, otherwise go to BUSY with the counter loaded to LATENCY-1.
REQ-016 BUSY SHALL decrement the counter each cycle and move to RESP when the counter reaches 1; ack_o SHALL therefore rise exactly LATENCY cycles after the acceptance cycle.
REQ-017 RESP SHALL assert ack_o for one cycle, then return to IDLE unconditionally; no acceptance is allowed in RESP.
REQ-018 Maximum throughput SHALL be one operation per LATENCY+1 cycles.
REQ-019 stall_o SHALL be combinational and equal 1 when (IDLE and accepting) or BUSY; it SHALL be 0 in RESP and in non-accepting IDLE cycles.
REQ-020 Req_i, Mem_i, Memaddr_i and Memdata_i SHALL be sampled only at the acceptance edge; changes to them during BUSY or RESP SHALL have no effect.
REQ-021 Error condition, evaluated at acceptance: Memaddr_i[1:0] != 0, or Memaddr_i >= DEPTH_WORDS*4.
REQ-022 Word index SHALL be Memaddr_i[log2(DEPTH_WORDS)+1:2].
REQ-023 A non-error store SHALL write Memdata_i to the array at the acceptance edge.
REQ-024 A non-error load SHALL capture the array word into rdata_o at the acceptance edge.
REQ-025 An error operation SHALL not write the array, SHALL set rdata_o to 0, and SHALL latch err_o=1 for its ack cycle.
REQ-026 Normal timing SHALL apply to error operations: err_o SHALL be 0 in every non-ack cycle.
REQ-027 rdata_o SHALL hold its value until the next load or error acceptance; a store SHALL leave rdata_o unchanged.
REQ-028 A load following a store to the same word SHALL return the stored data.

Reset
REQ-029 While rst_i=1: state goes to IDLE, counter 0, rdata_o 0, ack_o 0, err_o 0.
REQ-030 stall_o SHALL be 0 in the cycle after reset is released, provided req_i=0.
REQ-031 Reset asserted mid-operation (BUSY or RESP) SHALL abort the operation with no ack_o.
REQ-032 A store that was already accepted before that reset SHALL remain written.
REQ-033 Array contents SHALL not be reset.

Structure
REQ-034 Package dmem_pkg SHALL hold the op encodings (OP_NONE, OP_LOAD, OP_STORE), the state enum, and the defaults for DEPTH_WORDS and LATENCY.
REQ-035 Sub-module dmem_array SHALL be a single-port word RAM with synchronous write and combinational read; the FSM, counter and error logic SHALL live in dmem_responder.

Verification
REQ-036 Store then load, LATENCY=2: store 0xDEADBEEF to 0x10, then load 0x10 -> each ack_o 2 cycles after its acceptance; load returns rdata_o=0xDEADBEEF, err_o=0; stall_o high for 2 cycles per operation.
REQ-037 Misaligned load of 0x13 -> ack_o after LATENCY cycles, err_o=1, rdata_o=0; a later load of 0x10 is unaffected.
REQ-038 Out-of-range store to 0x400 (DEPTH_WORDS=256), then load 0x0 -> err_o=1 on the store; word 0 is unchanged (no wrap-around write).
REQ-039 Reset: assert rst_i during BUSY of a store to 0x20 -> no ack_o, state IDLE, stall_o=0; a subsequent load of 0x20 returns the stored data.
REQ-040 Back-to-back with LATENCY=1: req_i held high with alternating ops -> acceptances exactly 2 cycles apart; Mem_i=11 or req_i=0 never asserts stall_o.
